// File: rtl/ifid_hazard_ctrl_if.sv
// Interface bundling the hazard inputs from ID/EX and the fetch-control
// outputs that steer the PC mux and the IF/ID and ID/EX registers.
// The pipeline datapath is the master; the hazard controller is the slave.
interface ifid_hazard_ctrl_if;

   // Hazard detection inputs
   logic       ex_mem_read;
   logic [2:0] ex_rd;
   logic [2:0] id_rs1;
   logic [2:0] id_rs2;
   logic [1:0] id_rs_used;
   logic       ex_is_ctrl;
   logic       ex_branch_taken;
   logic       int_req;
   logic       rti_done;

   // Fetch / pipeline control outputs
   logic       pc_write;
   logic [1:0] pc_sel;
   logic       ifid_write;
   logic       ifid_flush;
   logic       idex_bubble;
   logic       int_save;
   logic       int_ack;
   logic       in_service;

   modport master (
      output ex_mem_read,
      output ex_rd,
      output id_rs1,
      output id_rs2,
      output id_rs_used,
      output ex_is_ctrl,
      output ex_branch_taken,
      output int_req,
      output rti_done,
      input  pc_write,
      input  pc_sel,
      input  ifid_write,
      input  ifid_flush,
      input  idex_bubble,
      input  int_save,
      input  int_ack,
      input  in_service
   );

   modport slave (
      input  ex_mem_read,
      input  ex_rd,
      input  id_rs1,
      input  id_rs2,
      input  id_rs_used,
      input  ex_is_ctrl,
      input  ex_branch_taken,
      input  int_req,
      input  rti_done,
      output pc_write,
      output pc_sel,
      output ifid_write,
      output ifid_flush,
      output idex_bubble,
      output int_save,
      output int_ack,
      output in_service
   );

endinterface

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID hazard controller.
// Decides every cycle whether fetch advances, stalls for a load-use hazard,
// is flushed by a taken branch, or is redirected into the interrupt entry
// sequence (flush, INT_CYCLES push micro-ops, then vector fetch).
// All control outputs are combinational from the current state and inputs;
// only the FSM state, the push counter and in_service are registered.
// INT_CYCLES must lie in 1..7 and fit in CNT_W bits.
module ifid_hazard_ctrl #(
   parameter int INT_CYCLES = 2,
   parameter int CNT_W      = 3
) (
   input logic              clk,
   input logic              rst_n,
   ifid_hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      STALL    = 2'd1,
      INT_SAVE = 2'd2,
      INT_JUMP = 2'd3
   } state_t;

   localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_SEL_VECTOR = 2'b10;

   // Counter value on the last INT_SAVE cycle
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(INT_CYCLES - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             inService_q;
   logic             inService_d;

   logic             rs1Hit;
   logic             rs2Hit;
   logic             loadUse;
   logic             intEligible;

   logic             pcWrite;
   logic [1:0]       pcSel;
   logic             ifidWrite;
   logic             ifidFlush;
   logic             idexBubble;
   logic             intSave;
   logic             intAck;

   // Load-use detection: a load in EX writing a register that the
   // instruction in IF/ID actually reads must be separated by one bubble.
   always_comb begin
      rs1Hit  = hz.id_rs_used[0] && (hz.ex_rd == hz.id_rs1);
      rs2Hit  = hz.id_rs_used[1] && (hz.ex_rd == hz.id_rs2);
      loadUse = hz.ex_mem_read && (rs1Hit || rs2Hit);
      // An interrupt is only taken at a clean boundary: no nesting, no
      // unresolved control transfer in EX and no pending load-use stall.
      intEligible = hz.int_req && !inService_q && !hz.ex_is_ctrl && !loadUse;
   end

   // Next-state and output decode; outputs default to free-running fetch
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      inService_d = inService_q;
      pcWrite     = 1'b1;
      pcSel       = PC_SEL_SEQ;
      ifidWrite   = 1'b1;
      ifidFlush   = 1'b0;
      idexBubble  = 1'b0;
      intSave     = 1'b0;
      intAck      = 1'b0;

      if (!rst_n) begin
         // Reset keeps outputs at the free-running defaults and forces the
         // registered state back to RUN, dropping any interrupt in flight.
         state_d     = RUN;
         count_d     = '0;
         inService_d = 1'b0;
      end else begin
         if (hz.rti_done) begin
            inService_d = 1'b0;
         end

         case (state_q)
            RUN: begin
               if (hz.ex_branch_taken) begin
                  pcSel      = PC_SEL_BRANCH;
                  ifidFlush  = 1'b1;
                  idexBubble = 1'b1;
               end else if (intEligible) begin
                  pcWrite   = 1'b0;
                  ifidWrite = 1'b0;
                  ifidFlush = 1'b1;
                  count_d   = '0;
                  state_d   = INT_SAVE;
               end else if (loadUse) begin
                  pcWrite    = 1'b0;
                  ifidWrite  = 1'b0;
                  idexBubble = 1'b1;
                  state_d    = STALL;
               end
            end

            STALL: begin
               // The bubble has already resolved the hazard, so load-use is
               // ignored here; a taken branch still redirects fetch.
               if (hz.ex_branch_taken) begin
                  pcSel      = PC_SEL_BRANCH;
                  ifidFlush  = 1'b1;
                  idexBubble = 1'b1;
               end
               state_d = RUN;
            end

            INT_SAVE: begin
               // Fetch frozen while ID/EX carries the return PC/flags pushes;
               // the sequence runs to completion even if int_req drops.
               pcWrite   = 1'b0;
               ifidWrite = 1'b0;
               ifidFlush = 1'b1;
               intSave   = 1'b1;
               count_d   = count_q + CNT_W'(1);
               if (count_q == LAST_COUNT) begin
                  state_d = INT_JUMP;
               end
            end

            INT_JUMP: begin
               // Fetch from the interrupt vector; setting in_service here
               // overrides a coincident rti_done.
               pcSel       = PC_SEL_VECTOR;
               ifidFlush   = 1'b1;
               intAck      = 1'b1;
               inService_d = 1'b1;
               state_d     = RUN;
            end

            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   // State, push counter and in-service flag registers
   always_ff @(posedge clk) begin
      state_q     <= state_d;
      count_q     <= count_d;
      inService_q <= inService_d;
   end

   assign hz.pc_write    = pcWrite;
   assign hz.pc_sel      = pcSel;
   assign hz.ifid_write  = ifidWrite;
   assign hz.ifid_flush  = ifidFlush;
   assign hz.idex_bubble = idexBubble;
   assign hz.int_save    = intSave;
   assign hz.int_ack     = intAck;
   assign hz.in_service  = inService_q;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Table-driven bench for ifid_hazard_ctrl with INT_CYCLES=2.
// Each record is one clock cycle: inputs driven after the falling edge,
// outputs compared shortly afterwards, state advancing on the rising edge.
// Expected outputs are packed as
// {pc_write, pc_sel[1:0], ifid_write, ifid_flush, idex_bubble, int_save, int_ack, in_service}.
module tb_ifid_hazard_ctrl;

   typedef struct {
      string      name;
      logic       rstN;
      logic       memRead;
      logic [2:0] exRd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [1:0] rsUsed;
      logic       isCtrl;
      logic       brTaken;
      logic       intReq;
      logic       rtiDone;
      logic [8:0] expOut;
   } vec_t;

   localparam logic [8:0] RUN_DEF  = 9'b1_00_1_0_0_0_0_0;
   localparam logic [8:0] BRANCH   = 9'b1_01_1_1_1_0_0_0;
   localparam logic [8:0] LOADUSE  = 9'b0_00_0_0_1_0_0_0;
   localparam logic [8:0] INTENTRY = 9'b0_00_0_1_0_0_0_0;
   localparam logic [8:0] INTSAVE  = 9'b0_00_0_1_0_1_0_0;
   localparam logic [8:0] INTJUMP  = 9'b1_10_1_1_0_0_1_0;
   localparam logic [8:0] SVC      = 9'b0_00_0_0_0_0_0_1;

   logic clk;
   logic rst_n;
   int   vectorsApplied;
   int   miscompares;
   vec_t vecs[$];

   ifid_hazard_ctrl_if hz();

   ifid_hazard_ctrl #(.INT_CYCLES(2), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkVec(string name, logic rstN, logic memRead,
                                  logic [2:0] exRd, logic [2:0] rs1, logic [2:0] rs2,
                                  logic [1:0] rsUsed, logic isCtrl, logic brTaken,
                                  logic intReq, logic rtiDone, logic [8:0] expOut);
      vec_t v;
      v.name    = name;
      v.rstN    = rstN;
      v.memRead = memRead;
      v.exRd    = exRd;
      v.rs1     = rs1;
      v.rs2     = rs2;
      v.rsUsed  = rsUsed;
      v.isCtrl  = isCtrl;
      v.brTaken = brTaken;
      v.intReq  = intReq;
      v.rtiDone = rtiDone;
      v.expOut  = expOut;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      rst_n              = v.rstN;
      hz.ex_mem_read     = v.memRead;
      hz.ex_rd           = v.exRd;
      hz.id_rs1          = v.rs1;
      hz.id_rs2          = v.rs2;
      hz.id_rs_used      = v.rsUsed;
      hz.ex_is_ctrl      = v.isCtrl;
      hz.ex_branch_taken = v.brTaken;
      hz.int_req         = v.intReq;
      hz.rti_done        = v.rtiDone;
      #2;
   endtask

   task automatic checkOutput(input vec_t v);
      logic [8:0] got;
      got = {hz.pc_write, hz.pc_sel, hz.ifid_write, hz.ifid_flush,
             hz.idex_bubble, hz.int_save, hz.int_ack, hz.in_service};
      vectorsApplied++;
      if (got !== v.expOut) begin
         miscompares++;
         $display("[TB] FAIL %s: got %b required %b", v.name, got, v.expOut);
      end
   endtask

   task automatic runVec(input vec_t v);
      applyStimulus(v);
      checkOutput(v);
   endtask

   initial begin
      vectorsApplied = 0;
      miscompares    = 0;

      // Inputs idle, reset held across two rising edges
      rst_n              = 1'b0;
      hz.ex_mem_read     = 1'b0;
      hz.ex_rd           = 3'd0;
      hz.id_rs1          = 3'd0;
      hz.id_rs2          = 3'd0;
      hz.id_rs_used      = 2'b00;
      hz.ex_is_ctrl      = 1'b0;
      hz.ex_branch_taken = 1'b0;
      hz.int_req         = 1'b0;
      hz.rti_done        = 1'b0;
      repeat (2) @(posedge clk);

      //                   name            rst mr exRd  rs1   rs2   used   ctl br int rti expected
      vecs.push_back(mkVec("reset_events", 0, 1, 3'd3, 3'd3, 3'd0, 2'b01, 0, 1, 1, 0, RUN_DEF));
      vecs.push_back(mkVec("idle",         1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, RUN_DEF));
      vecs.push_back(mkVec("lu_rs1",       1, 1, 3'd3, 3'd3, 3'd0, 2'b01, 0, 0, 0, 0, LOADUSE));
      vecs.push_back(mkVec("stall_masked", 1, 1, 3'd3, 3'd3, 3'd0, 2'b01, 0, 0, 0, 0, RUN_DEF));
      vecs.push_back(mkVec("lu_again_run", 1, 1, 3'd3, 3'd3, 3'd0, 2'b01, 0, 0, 0, 0, LOADUSE));
      vecs.push_back(mkVec("stall_idle",   1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, RUN_DEF));
      vecs.push_back(mkVec("lu_rs2",       1, 1, 3'd5, 3'd2, 3'd5, 2'b10, 0, 0, 0, 0, LOADUSE));
      vecs.push_back(mkVec("stall_rs2",    1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, RUN_DEF));
      vecs.push_back(mkVec("rs1_unused",   1, 1, 3'd4, 3'd4, 3'd1, 2'b10, 0, 0, 0, 0, RUN_DEF));
      vecs.push_back(mkVec("no_load",      1, 0, 3'd4, 3'd4, 3'd4, 2'b11, 0, 0, 0, 0, RUN_DEF));
      vecs.push_back(mkVec("br_priority",  1, 1, 3'd3, 3'd3, 3'd0, 2'b01, 0, 1, 1, 0, BRANCH));
      vecs.push_back(mkVec("after_br",     1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, RUN_DEF));
      vecs.push_back(mkVec("lu_pre_br",    1, 1, 3'd6, 3'd6, 3'd0, 2'b01, 0, 0, 0, 0, LOADUSE));
      vecs.push_back(mkVec("br_in_stall",  1, 1, 3'd6, 3'd6, 3'd0, 2'b01, 0, 1, 0, 0, BRANCH));
      vecs.push_back(mkVec("run_after_st", 1, 1, 3'd6, 3'd6, 3'd0, 2'b01, 0, 0, 0, 0, LOADUSE));
      vecs.push_back(mkVec("stall_2",      1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, RUN_DEF));
      // Interrupt entry; int_req dropped and a stray branch inside INT_SAVE
      vecs.push_back(mkVec("int_accept",   1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, INTENTRY));
      vecs.push_back(mkVec("int_save0",    1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, INTSAVE));
      vecs.push_back(mkVec("int_save1_br", 1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 1, 0, 0, INTSAVE));
      vecs.push_back(mkVec("int_jump",     1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, INTJUMP));
      vecs.push_back(mkVec("svc_block0",   1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, RUN_DEF | SVC));
      vecs.push_back(mkVec("svc_block1",   1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, RUN_DEF | SVC));
      vecs.push_back(mkVec("rti_pulse",    1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 1, RUN_DEF | SVC));
      vecs.push_back(mkVec("reentry",      1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, INTENTRY));
      vecs.push_back(mkVec("re_save0",     1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, INTSAVE));
      vecs.push_back(mkVec("re_save1",     1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, INTSAVE));
      vecs.push_back(mkVec("jump_rti",     1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 1, INTJUMP));
      vecs.push_back(mkVec("set_wins",     1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, RUN_DEF | SVC));
      vecs.push_back(mkVec("rst_svc",      0, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, RUN_DEF | SVC));
      vecs.push_back(mkVec("svc_cleared",  1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, RUN_DEF));
      // Interrupt deferred by a control instruction in EX
      vecs.push_back(mkVec("defer_ctrl0",  1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 1, 0, 1, 0, RUN_DEF));
      vecs.push_back(mkVec("defer_ctrl1",  1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 1, 0, 1, 0, RUN_DEF));
      vecs.push_back(mkVec("defer_ctrl2",  1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 1, 0, 1, 0, RUN_DEF));
      vecs.push_back(mkVec("defer_accept", 1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, INTENTRY));
      vecs.push_back(mkVec("defer_save0",  1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, INTSAVE));
      vecs.push_back(mkVec("defer_save1",  1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, INTSAVE));
      vecs.push_back(mkVec("defer_jump",   1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, INTJUMP));
      vecs.push_back(mkVec("defer_rti",    1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 1, RUN_DEF | SVC));
      // Interrupt deferred by load-use, not taken inside the stall cycle
      vecs.push_back(mkVec("defer_lu",     1, 1, 3'd2, 3'd7, 3'd2, 2'b11, 0, 0, 1, 0, LOADUSE));
      vecs.push_back(mkVec("defer_lu_st",  1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, RUN_DEF));
      vecs.push_back(mkVec("lu_accept",    1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, INTENTRY));

      for (int i = 0; i < vecs.size(); i++) begin
         runVec(vecs[i]);
      end

      // Hand sequence: reset asserted during the first INT_SAVE cycle
      // (the controller is in INT_SAVE after lu_accept above)
      runVec(mkVec("rst_mid_save", 0, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, RUN_DEF));
      runVec(mkVec("post_rst_run", 1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, RUN_DEF));
      runVec(mkVec("post_rst_lu",  1, 1, 3'd1, 3'd1, 3'd0, 2'b01, 0, 0, 0, 0, LOADUSE));
      runVec(mkVec("post_rst_st",  1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, RUN_DEF));

      // Hand sequence: full entry after reset proves the counter restarted
      runVec(mkVec("cnt_accept",   1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1, 0, INTENTRY));
      runVec(mkVec("cnt_save0",    1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, INTSAVE));
      runVec(mkVec("cnt_save1",    1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, INTSAVE));
      runVec(mkVec("cnt_jump",     1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, INTJUMP));
      runVec(mkVec("cnt_svc",      1, 0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 0, RUN_DEF | SVC));

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule

// File: doc/ifid_hazard_ctrl.md
Name: ifid_hazard_ctrl

Overview:
- Controls the IF/ID pipeline register and the PC update path.
- Decides each cycle whether fetch advances, stalls, is flushed or is redirected.
- Covers three cases: load-use hazards, taken branches resolved in EX, and interrupt entry.
- Drives the write enable and flush of the IF/ID register, the bubble insert into ID/EX, and the PC source select.

Parameters:
- INT_CYCLES, 2: cycles spent in INT_SAVE pushing return PC/flags (legal range 1..7).
- CNT_W, 3: width of the INT_SAVE cycle counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  3  destination register of the instruction in EX.
- id_rs1  in  3  source register 1 of the instruction in IF/ID.
- id_rs2  in  3  source register 2 of the instruction in IF/ID.
- id_rs_used  in  2  bit0 = rs1 used, bit1 = rs2 used.
- ex_is_ctrl  in  1  EX holds a branch/jump, resolved or not.
- ex_branch_taken  in  1  EX resolved a taken branch this cycle.
- int_req  in  1  level-sensitive external interrupt request.
- rti_done  in  1  one-cycle pulse: return-from-interrupt retired.
- pc_write  out  1  PC register load enable.
- pc_sel  out  2  00 = PC+1, 01 = branch target, 10 = interrupt vector, 11 = reserved (never driven).
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  zero IF/ID contents this cycle.
- idex_bubble  out  1  load a NOP into ID/EX; marks it as a bubble.
- int_save  out  1  ID/EX slot carries a PC/flags push micro-op.
- int_ack  out  1  one-cycle interrupt acknowledge.
- in_service  out  1  interrupt handler active.

Behaviour:
- Output timing: all outputs are combinational from state plus inputs (zero-cycle latency). in_service is the only registered flag.
- load_use = ex_mem_read & ((id_rs_used[0] & ex_rd==id_rs1) | (id_rs_used[1] & ex_rd==id_rs2)).
- Default outputs (RUN, no event): pc_write=1, pc_sel=00, ifid_write=1, all other outputs 0.
- States: RUN, STALL, INT_SAVE, INT_JUMP. Reset state is RUN with counter=0 and in_service=0.
- While rst_n=0, the combinational outputs follow the RUN defaults with no events. The registered state is forced at the clock edge. An active reset in any state (including mid INT_SAVE) returns to RUN next cycle, clears the counter and in_service, and discards any pending interrupt.
- RUN priority, highest first:
  (1) ex_branch_taken: pc_sel=01, pc_write=1, ifid_flush=1, idex_bubble=1; stay RUN.
  (2) int_req & !in_service & !ex_is_ctrl & !load_use: pc_write=0, ifid_write=0, ifid_flush=1; counter<=0; go to INT_SAVE.
  (3) load_use: pc_write=0, ifid_write=0, idex_bubble=1; go to STALL.
  (4) Otherwise: default outputs.
- STALL: lasts exactly one cycle. load_use is masked. Default outputs, except that ex_branch_taken applies rule (1). Always returns to RUN.
- INT_SAVE:
  - Outputs: pc_write=0, ifid_write=0, ifid_flush=1, int_save=1.
  - Counter increments each cycle; when counter==INT_CYCLES-1, go to INT_JUMP.
  - ex_branch_taken cannot occur here, because entry requires ex_is_ctrl=0. If it does occur, it is ignored.
  - Dropping int_req here does not abort the sequence.
- INT_JUMP: one cycle. pc_sel=10, pc_write=1, ifid_flush=1, int_ack=1. Sets in_service; go to RUN.
- in_service: while set, int_req is ignored (no nesting). It clears on rti_done. If rti_done and an INT_JUMP occur in the same cycle, the set wins.
- Interrupt blocked by ex_is_ctrl or load_use: stays pending as long as int_req is held. It is re-evaluated in the first RUN cycle where it is eligible.
- Total interrupt entry: 1 (RUN decision) + INT_CYCLES + 1 cycles from acceptance to the vector fetch.
- Invariant: pc_write=0 with ifid_write=1 is never driven.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=3, id_rs1=3, id_rs_used=01 in RUN.
  - Same cycle: pc_write=0, ifid_write=0, idex_bubble=1.
  - Next cycle: STALL with default outputs, even if load_use is still 1.
  - Cycle after: RUN.
- Branch: ex_branch_taken=1 in RUN with load_use=1 and int_req=1.
  - Required: pc_sel=01, pc_write=1, ifid_flush=1, idex_bubble=1; state stays RUN; no stall or interrupt entry that cycle.
- Interrupt with INT_CYCLES=2: int_req=1 in RUN with ex_is_ctrl=0.
  - Required sequence: 1 RUN-flush cycle, 2 cycles of int_save=1, 1 INT_JUMP cycle (pc_sel=10, int_ack=1).
  - Then in_service=1; a new int_req gives no re-entry until an rti_done pulse, after which entry is possible again.
- Deferred interrupt: int_req=1 while ex_is_ctrl=1 for 3 cycles.
  - No INT_SAVE during those cycles; entry occurs in the first cycle ex_is_ctrl=0.
- Reset mid-sequence: rst_n=0 during the first INT_SAVE cycle.
  - Next cycle: RUN, int_save=0, in_service=0, pc_write=1, pc_sel=00.
